// File: rtl/hilo_unit_if.sv
// rtl/hilo_unit_if.sv - pipeline-side bundle for the HI/LO register unit
//
// Groups the EX-stage signals exchanged with hilo_unit.
//   master : pipeline side (drives divide results, mt/mf requests, flush)
//   slave  : hilo_unit side (drives rd_data, stall, busy, hi, lo)
interface hilo_unit_if;
   logic        div_start;
   logic [31:0] div_hi_in;
   logic [31:0] div_lo_in;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wr_data;
   logic        mfhi;
   logic        mflo;
   logic        flush;
   logic [31:0] rd_data;
   logic        stall;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output div_start, div_hi_in, div_lo_in, mthi, mtlo, wr_data, mfhi, mflo, flush,
      input  rd_data, stall, busy, hi, lo
   );

   modport slave (
      input  div_start, div_hi_in, div_lo_in, mthi, mtlo, wr_data, mfhi, mflo, flush,
      output rd_data, stall, busy, hi, lo
   );
endinterface

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - execute-stage HI/LO registers with modelled divide latency
//
// Captures the ALU divide remainder/quotient, holds them pending for
// DIV_LATENCY cycles, then commits them to HI/LO. Services mthi/mtlo writes
// and mfhi/mflo reads, stalling reads that would see an uncommitted divide.
//
// Ports:
//   clk    : pipeline clock, rising edge
//   rst_b  : asynchronous active-low reset
//   bus    : hilo_unit_if.slave
//            in : div_start, div_hi_in, div_lo_in, mthi, mtlo, wr_data,
//                 mfhi, mflo, flush
//            out: rd_data (comb), stall (comb), busy, hi, lo
//
// Parameter DIV_LATENCY (1..32): cycles from div_start until HI/LO hold the result.
// Macro HILO_FWD_EN: forward the committing half to rd_data in the final
// BUSY cycle instead of stalling.
module hilo_unit #(
   parameter int DIV_LATENCY = 4
) (
   input  logic       clk,
   input  logic       rst_b,
   hilo_unit_if.slave bus
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam logic [4:0] CNT_LOAD = 5'(DIV_LATENCY - 1);

   logic [0:0]  state_q,     state_d;
   logic [4:0]  count_q,     count_d;
   logic [31:0] hi_q,        hi_d;
   logic [31:0] lo_q,        lo_d;
   logic [31:0] pend_hi_q,   pend_hi_d;
   logic [31:0] pend_lo_q,   pend_lo_d;
   logic        cancel_hi_q, cancel_hi_d;
   logic        cancel_lo_q, cancel_lo_d;

   logic        busy;
   logic        commit_now;
   logic        fwd_ok;
   logic [31:0] rd_hi;
   logic [31:0] rd_lo;

   assign busy       = (state_q == S_BUSY);
   assign commit_now = busy && (count_q == 5'd0);

   // Next-state logic. flush overrides everything; a restart (div_start while
   // busy) discards the old pending result before it can commit.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      pend_hi_d   = pend_hi_q;
      pend_lo_d   = pend_lo_q;
      cancel_hi_d = cancel_hi_q;
      cancel_lo_d = cancel_lo_q;

      if (bus.flush) begin
         state_d = S_IDLE;
         count_d = 5'd0;
      end else begin
         // Commit first so that a same-edge mthi/mtlo overrides its half.
         if (commit_now && !bus.div_start) begin
            if (!cancel_hi_q) hi_d = pend_hi_q;
            if (!cancel_lo_q) lo_d = pend_lo_q;
         end

         if (bus.mthi) hi_d = bus.wr_data;
         if (bus.mtlo) lo_d = bus.wr_data;

         if (bus.div_start) begin
            state_d     = S_BUSY;
            count_d     = CNT_LOAD;
            pend_hi_d   = bus.div_hi_in;
            pend_lo_d   = bus.div_lo_in;
            cancel_hi_d = 1'b0;
            cancel_lo_d = 1'b0;
         end else if (busy) begin
            // A direct write while the divide is in flight owns that half.
            if (bus.mthi) cancel_hi_d = 1'b1;
            if (bus.mtlo) cancel_lo_d = 1'b1;
            if (count_q == 5'd0) begin
               state_d = S_IDLE;
            end else begin
               count_d = count_q - 5'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= S_IDLE;
         count_q     <= 5'd0;
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
         pend_hi_q   <= 32'd0;
         pend_lo_q   <= 32'd0;
         cancel_hi_q <= 1'b0;
         cancel_lo_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         pend_hi_q   <= pend_hi_d;
         pend_lo_q   <= pend_lo_d;
         cancel_hi_q <= cancel_hi_d;
         cancel_lo_q <= cancel_lo_d;
      end
   end

   // Read path: in the commit cycle the forwarded value is whatever HI/LO
   // will hold after this edge (ignoring a same-cycle mthi/mtlo, since reads
   // observe pre-edge state).
`ifdef HILO_FWD_EN
   assign fwd_ok = commit_now;
   assign rd_hi  = (commit_now && !cancel_hi_q) ? pend_hi_q : hi_q;
   assign rd_lo  = (commit_now && !cancel_lo_q) ? pend_lo_q : lo_q;
`else
   assign fwd_ok = 1'b0;
   assign rd_hi  = hi_q;
   assign rd_lo  = lo_q;
`endif

   always_comb begin
      bus.rd_data = 32'd0;
      if (bus.mfhi) begin
         bus.rd_data = rd_hi;
      end else if (bus.mflo) begin
         bus.rd_data = rd_lo;
      end
   end

   assign bus.stall = (bus.mfhi | bus.mflo) & busy & ~bus.flush & ~fwd_ok;
   assign bus.busy  = busy;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;

endmodule
